// File: rtl/dcache_resp.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data cache
// sitting between the CPU pipeline and a valid/ready backing memory.
module dcache_resp #(
  parameter int unsigned LINES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  input  logic [3:0]  cpu_we,
  input  logic        cpu_re,
  output logic [31:0] cpu_dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic [3:0]  mem_req_we,
  output logic [31:0] mem_req_data,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_DONE = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];
  logic [31:0]      dout_q;

  logic [IDX_W-1:0] idx_c;
  logic [TAG_W-1:0] tag_c;
  logic             hit_c;
  logic             is_store_c;
  logic             fill_c;
  logic             merge_c;
  logic             load_hit_c;
  logic             unused_addr_bits;

  assign idx_c            = cpu_addr[IDX_W+1:2];
  assign tag_c            = cpu_addr[31:IDX_W+2];
  assign hit_c            = valid_q[idx_c] && (tag_q[idx_c] == tag_c);
  assign is_store_c       = |cpu_we;
  assign unused_addr_bits = ^cpu_addr[1:0];
  assign cpu_dout         = dout_q;

  // Next state, stall and memory request; request fields are zero when not valid.
  always_comb begin
    state_d       = state_q;
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = 32'h0;
    mem_req_we    = 4'h0;
    mem_req_data  = 32'h0;
    fill_c        = 1'b0;
    merge_c       = 1'b0;
    load_hit_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_store_c) begin
          stall   = 1'b1;
          state_d = WR_REQ;
        end else if (cpu_re) begin
          if (hit_c) begin
            load_hit_c = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_addr  = {cpu_addr[31:2], 2'b00};
        if (mem_req_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        stall = 1'b1;
        if (mem_resp_valid) begin
          fill_c  = 1'b1;
          state_d = IDLE;
        end
      end
      WR_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_addr  = {cpu_addr[31:2], 2'b00};
        mem_req_we    = cpu_we;
        mem_req_data  = cpu_din;
        if (mem_req_ready) begin
          merge_c = hit_c;
          state_d = WR_DONE;
        end
      end
      WR_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      dout_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (fill_c) valid_q[idx_c] <= 1'b1;
      if (load_hit_c) dout_q <= data_q[idx_c];
    end
  end

  // Tag/data storage carries no reset; valid bits guard every use.
  always_ff @(posedge clk) begin
    if (fill_c) begin
      tag_q[idx_c]  <= tag_c;
      data_q[idx_c] <= mem_resp_data;
    end else if (merge_c) begin
      for (int b = 0; b < 4; b++) begin
        if (cpu_we[b]) data_q[idx_c][8*b +: 8] <= cpu_din[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dcache_resp.sv
// Randomized bench for dcache_resp: transaction-level cache/memory model,
// backing-memory responder with variable ready delay and response latency.
module tb_dcache_resp;

  localparam int unsigned LINES = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_din = 32'h0;
  logic [3:0]  cpu_we = 4'h0;
  logic        cpu_re = 1'b0;
  logic [31:0] cpu_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic [3:0]  mem_req_we;
  logic [31:0] mem_req_data;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'h0;

  always #5 clk = ~clk;

  dcache_resp #(.LINES(LINES)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_addr      (cpu_addr),
    .cpu_din       (cpu_din),
    .cpu_we        (cpu_we),
    .cpu_re        (cpu_re),
    .cpu_dout      (cpu_dout),
    .stall         (stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_we    (mem_req_we),
    .mem_req_data  (mem_req_data),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: backing memory words plus which tag each line holds.
  logic [31:0] mem [logic [29:0]];
  bit          mv  [LINES];
  logic [23:0] mt  [LINES];
  logic [31:0] dout_exp = 32'h0;

  function automatic logic [31:0] mem_rd(input logic [29:0] w);
    if (mem.exists(w)) return mem[w];
    return {w[15:0], ~w[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = din[8*b +: 8];
    return r;
  endfunction

  // One CPU request held until accepted; memory side answered on the fly.
  task automatic access(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] din,
                        input logic re, input int rdy_dly, input int lat, output bit missed);
    logic [5:0]  idx;
    logic [23:0] tg;
    logic [29:0] w;
    bit          exp_hit, store, done, v, st;
    int          cyc, wait_cnt, resp_cnt, req_cnt;
    idx = addr[7:2];
    tg  = addr[31:8];
    w   = addr[31:2];
    store   = (we != 4'h0);
    exp_hit = mv[idx] && (mt[idx] == tg);
    cpu_addr = addr; cpu_we = we; cpu_din = din; cpu_re = re;
    cyc = 0; wait_cnt = 0; resp_cnt = 0; req_cnt = 0; done = 0;
    while (!done && cyc < 200) begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_rd(w);
        end
      end
      mem_req_ready = (wait_cnt >= rdy_dly);
      #1;
      st = stall;
      v  = mem_req_valid;
      if (cyc == 0) chk("first_stall", 32'(st), 32'(store || !exp_hit));
      if (v) begin
        chk("req_addr", mem_req_addr, {addr[31:2], 2'b00});
        chk("req_we", 32'(mem_req_we), 32'(store ? we : 4'h0));
        chk("req_data", mem_req_data, store ? din : 32'h0);
        wait_cnt++;
        if (mem_req_ready) begin
          req_cnt++;
          if (!store) resp_cnt = lat;
        end
      end else begin
        chk("idle_req_fields", mem_req_addr | mem_req_data | 32'(mem_req_we), 32'h0);
      end
      if (!st) done = 1;
      @(negedge clk);
      cyc++;
    end
    if (!done) chk("accept_timeout", 32'(done), 32'h1);
    cpu_re = 1'b0; cpu_we = 4'h0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    missed = (req_cnt > 0);
    if (store) begin
      chk("store_reqs", 32'(req_cnt), 32'h1);
      mem[w] = merge(mem_rd(w), din, we);
    end else begin
      chk("load_miss", 32'(missed), 32'(!exp_hit));
      chk("load_reqs", 32'(req_cnt), exp_hit ? 32'h0 : 32'h1);
      mv[idx] = 1'b1;
      mt[idx] = tg;
      dout_exp = mem_rd(w);
    end
    #1 chk("dout", cpu_dout, dout_exp);
  endtask

  // Idle cycle, optionally with a stray memory response that must be ignored.
  task automatic idle(input bit spurious);
    if (spurious) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = $urandom;
    end
    #1;
    chk("idle_stall", 32'(stall), 32'h0);
    chk("idle_dout", cpu_dout, dout_exp);
    @(negedge clk);
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    bit          m, got;
    int          cyc;
    logic [31:0] a, d;
    logic [3:0]  we;

    for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
    mem[30'h40] = 32'hDEADBEEF;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_dout", cpu_dout, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    access(32'h100, 4'h0, 32'h0, 1'b1, 0, 2, m);
    chk("cold_miss", 32'(m), 32'h1);
    chk("cold_dout", cpu_dout, 32'hDEADBEEF);
    access(32'h100, 4'h0, 32'h0, 1'b1, 0, 1, m);
    chk("warm_hit", 32'(m), 32'h0);
    chk("warm_dout", cpu_dout, 32'hDEADBEEF);

    access(32'h102, 4'b1100, 32'h12340000, 1'b0, 3, 1, m);
    access(32'h100, 4'h0, 32'h0, 1'b1, 0, 1, m);
    chk("merge_hit", 32'(m), 32'h0);
    chk("merge_dout", cpu_dout, 32'h1234BEEF);

    access(32'h400, 4'hF, 32'h0BADC0DE, 1'b0, 1, 1, m);
    access(32'h400, 4'h0, 32'h0, 1'b1, 0, 2, m);
    chk("no_alloc_miss", 32'(m), 32'h1);

    access(32'h100, 4'h0, 32'h0, 1'b1, 0, 1, m);
    chk("alias_a_miss", 32'(m), 32'h1);
    access(32'h200, 4'h0, 32'h0, 1'b1, 2, 3, m);
    chk("alias_b_miss", 32'(m), 32'h1);
    access(32'h100, 4'h0, 32'h0, 1'b1, 0, 1, m);
    chk("alias_a_remiss", 32'(m), 32'h1);

    // Reset while the read is outstanding, then a late response arrives.
    a = 32'h304;
    cpu_addr = a; cpu_re = 1'b1; mem_req_ready = 1'b1;
    got = 0; cyc = 0;
    while (!got && cyc < 50) begin
      #1;
      if (mem_req_valid) got = 1;
      @(negedge clk);
      cyc++;
    end
    chk("rd_wait_reached", 32'(got), 32'h1);
    mem_req_ready = 1'b0;
    #1;
    chk("rd_wait_stall", 32'(stall), 32'h1);
    chk("rd_wait_noreq", 32'(mem_req_valid), 32'h0);
    reset = 1'b0;
    #1;
    chk("abort_dout", cpu_dout, 32'h0);
    chk("abort_req_valid", 32'(mem_req_valid), 32'h0);
    cpu_re = 1'b0;
    #1 chk("abort_stall", 32'(stall), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hCAFEF00D;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
    dout_exp = 32'h0;
    #1 chk("late_resp_dout", cpu_dout, 32'h0);
    access(a, 4'h0, 32'h0, 1'b1, 0, 1, m);
    chk("post_abort_miss", 32'(m), 32'h1);
    access(32'h100, 4'h0, 32'h0, 1'b1, 0, 1, m);
    chk("post_abort_miss2", 32'(m), 32'h1);

    for (int n = 0; n < 300; n++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
        | 32'($urandom_range(0, 3));
      d = $urandom;
      we = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      access(a, we, d, (we == 4'h0) ? 1'b1 : 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(1, 3), m);
      if ($urandom_range(0, 3) == 0) idle(1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
